param_comparator_pipe: RTL and testbench
========================================

Name: param_comparator_pipe

Overview:
Multi-lane, registered successor to the single combinational magnitude comparator. It compares LANES pairs of WIDTH-bit operands per transfer, in signed or unsigned mode selected per transfer. Results pass through a one-deep output register with a valid/ready handshake. It also tracks the previous accepted result per lane to flag changes and counts all-equal transfers. It sits between operand producers and threshold/sort logic that may apply backpressure.

Parameters:
WIDTH, 8, operand width per lane in bits (>=1)
LANES, 4, number of independent comparison lanes (>=1)
CNT_W, 16, width of the saturating all-equal transfer counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand transfer valid
in_ready  output  1  block can accept operands
in_signed  input  1  1: two's-complement compare, 0: unsigned; sampled with the transfer
in_a  input  LANES*WIDTH  lane i operand A at bits [i*WIDTH +: WIDTH]
in_b  input  LANES*WIDTH  lane i operand B, same packing
clr  input  1  synchronous clear of history and counter
out_valid  output  1  result register holds an unconsumed result
out_ready  input  1  consumer accepts result
out_eq  output  LANES  lane A==B
out_gt  output  LANES  lane A>B
out_lt  output  LANES  lane A<B
out_all_eq  output  1  AND of out_eq
out_changed  output  LANES  lane {lt,eq,gt} differs from the previous accepted transfer
eq_count  output  CNT_W  number of accepted transfers with all lanes equal, saturating

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_eq/out_gt/out_lt=0, out_all_eq=0, out_changed=0, eq_count=0, history valid flag=0, history registers=0.
- Handshake: in_ready = !out_valid | out_ready (combinational). A transfer is accepted when in_valid & in_ready.
- On an accepted transfer, the result register loads at the next edge and out_valid=1. Latency is 1 cycle. Back-to-back throughput is 1 per cycle while out_ready=1.
- If out_valid & out_ready and no transfer is accepted, out_valid goes to 0. Outputs hold their last values while out_valid=0.
- If out_valid & !out_ready, all outputs hold stable. in_ready=0, and in_* is ignored.
- Per lane, exactly one of eq/gt/lt is 1 whenever out_valid=1 (one-hot, never multiple bits).
- Signed mode compares operands as two's complement of WIDTH bits. Unsigned mode compares them as magnitudes. Example: WIDTH=8, 0x80 vs 0x01 gives lt in signed mode and gt in unsigned mode.
- History:
  - A registered copy of the last accepted per-lane {lt,eq,gt} plus a hist_valid flag.
  - out_changed[i] = hist_valid & (new lane result != stored lane result).
  - The first transfer after reset or clr gives out_changed=0. History updates on every accepted transfer.
- eq_count increments by 1 on each accepted transfer whose all lanes are equal. It saturates at 2^CNT_W-1 with no wrap.
- clr, synchronous, takes priority over counter/history update in the same cycle:
  - eq_count=0 and hist_valid=0.
  - A transfer accepted in the same cycle still loads the result register, with out_changed=0, and it is not counted.
  - clr does not affect out_valid or a pending result.
- Reset asserted mid-operation drops any pending result with no output. Operation after release restarts as from power-up.
- in_signed affects only its own transfer. A mode change between transfers needs no flush.

Test Plan:
1. Reset then single transfer, LANES=4, WIDTH=8, unsigned, A={10,20,30,40}, B={10,25,5,40}, out_ready=1 -> next cycle out_valid=1, eq=4'b1001, gt=4'b0100, lt=4'b0010, all_eq=0, changed=0.
2. Same lane 2 operands 0x80 vs 0x01 with in_signed=1 then in_signed=0 -> lane2 lt=1 then gt=1. Second result has changed[2]=1.
3. Backpressure: out_ready=0 for 3 cycles after a result, in_valid held -> in_ready=0, outputs frozen. Raising out_ready drains the result and accepts the next transfer in the same cycle, with no loss or duplication.
4. CNT_W=2, five all-equal transfers -> eq_count 1,2,3,3,3 (saturates).
5. Assert clr together with an accepted all-equal transfer when eq_count=2 -> eq_count=0, that result shows out_changed=0, and the following identical transfer shows changed=0 and eq_count=1.
6. Assert rst_n low while out_valid=1 and out_ready=0 -> out_valid=0 immediately with no clock edge needed, and all outputs read 0.

Source files
------------

// File: rtl/param_comparator_pipe.sv
// param_comparator_pipe
// Multi-lane magnitude comparator with a one-deep registered output stage.
// Each transfer compares LANES operand pairs, signed or unsigned as chosen
// for that transfer. A valid/ready handshake carries results downstream.
// The block also keeps the previous accepted per-lane result to flag
// changes, and a saturating count of transfers where every lane was equal.
module param_comparator_pipe #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_signed,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic                   clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       out_eq,
    output logic [LANES-1:0]       out_gt,
    output logic [LANES-1:0]       out_lt,
    output logic                   out_all_eq,
    output logic [LANES-1:0]       out_changed,
    output logic [CNT_W-1:0]       eq_count
);

    // Per-lane result code, ordered {lt, eq, gt}. Exactly one bit is set.
    localparam logic [2:0] CODE_LT = 3'b100;
    localparam logic [2:0] CODE_EQ = 3'b010;
    localparam logic [2:0] CODE_GT = 3'b001;

    // Compare one lane. In signed mode, inverting the sign bit of both
    // operands maps two's-complement ordering onto unsigned ordering, so a
    // single unsigned comparator serves both modes.
    function automatic logic [2:0] lane_cmp(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sgn
    );
        logic [WIDTH-1:0] ax;
        logic [WIDTH-1:0] bx;
        logic [2:0]       res;
        ax = a;
        bx = b;
        if (sgn) begin
            ax[WIDTH-1] = ~a[WIDTH-1];
            bx[WIDTH-1] = ~b[WIDTH-1];
        end else begin
            ax = a;
            bx = b;
        end
        if (ax == bx) begin
            res = CODE_EQ;
        end else if (ax > bx) begin
            res = CODE_GT;
        end else begin
            res = CODE_LT;
        end
        return res;
    endfunction

    // Handshake and combinational lane results
    logic                  accept_s;
    logic [LANES-1:0][2:0] code_s;
    logic [LANES-1:0]      eq_s;
    logic [LANES-1:0]      gt_s;
    logic [LANES-1:0]      lt_s;
    logic [LANES-1:0]      changed_s;
    logic                  all_eq_s;
    logic                  cnt_sat_s;

    // Output result register
    logic                  out_valid_r;
    logic [LANES-1:0]      eq_r;
    logic [LANES-1:0]      gt_r;
    logic [LANES-1:0]      lt_r;
    logic                  all_eq_r;
    logic [LANES-1:0]      changed_r;

    // History and counter state
    logic [LANES-1:0][2:0] hist_r;
    logic                  hist_valid_r;
    logic [CNT_W-1:0]      eq_count_r;

    // A new transfer fits when the result register is empty or is being drained.
    assign in_ready  = ~out_valid_r | out_ready;
    assign accept_s  = in_valid & in_ready;
    assign cnt_sat_s = (eq_count_r == {CNT_W{1'b1}});

    // Evaluate all lanes and their change flags against the stored history.
    // A transfer that coincides with clr is treated as the first after clear.
    always_comb begin
        code_s    = {(3*LANES){1'b0}};
        eq_s      = {LANES{1'b0}};
        gt_s      = {LANES{1'b0}};
        lt_s      = {LANES{1'b0}};
        changed_s = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            code_s[i]    = lane_cmp(in_a[i*WIDTH +: WIDTH], in_b[i*WIDTH +: WIDTH], in_signed);
            lt_s[i]      = code_s[i][2];
            eq_s[i]      = code_s[i][1];
            gt_s[i]      = code_s[i][0];
            changed_s[i] = hist_valid_r & ~clr & (code_s[i] != hist_r[i]);
        end
        all_eq_s = &eq_s;
    end

    // Result register: load on accept, empty on drain, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            eq_r        <= {LANES{1'b0}};
            gt_r        <= {LANES{1'b0}};
            lt_r        <= {LANES{1'b0}};
            all_eq_r    <= 1'b0;
            changed_r   <= {LANES{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            eq_r        <= eq_s;
            gt_r        <= gt_s;
            lt_r        <= lt_s;
            all_eq_r    <= all_eq_s;
            changed_r   <= changed_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // History of the last accepted lane codes; clr wipes it and wins over an update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r       <= {(3*LANES){1'b0}};
            hist_valid_r <= 1'b0;
        end else if (clr) begin
            hist_r       <= {(3*LANES){1'b0}};
            hist_valid_r <= 1'b0;
        end else if (accept_s) begin
            hist_r       <= code_s;
            hist_valid_r <= 1'b1;
        end else begin
            hist_valid_r <= hist_valid_r;
        end
    end

    // Saturating count of accepted all-equal transfers; clr zeroes it and
    // a transfer in the clearing cycle is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            eq_count_r <= {CNT_W{1'b0}};
        end else if (accept_s && all_eq_s && !cnt_sat_s) begin
            eq_count_r <= eq_count_r + CNT_W'(1);
        end else begin
            eq_count_r <= eq_count_r;
        end
    end

    assign out_valid   = out_valid_r;
    assign out_eq      = eq_r;
    assign out_gt      = gt_r;
    assign out_lt      = lt_r;
    assign out_all_eq  = all_eq_r;
    assign out_changed = changed_r;
    assign eq_count    = eq_count_r;

endmodule

// File: tb/tb_param_comparator_pipe.sv
// Testbench for param_comparator_pipe (WIDTH=8, LANES=4, CNT_W=2).
// Expected results come from a behavioural model and pass through a
// scoreboard queue from the stimulus step to the output check.
module tb_param_comparator_pipe;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_signed;
    logic [LANES*WIDTH-1:0] in_a;
    logic [LANES*WIDTH-1:0] in_b;
    logic                   clr;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES-1:0]       out_eq;
    logic [LANES-1:0]       out_gt;
    logic [LANES-1:0]       out_lt;
    logic                   out_all_eq;
    logic [LANES-1:0]       out_changed;
    logic [CNT_W-1:0]       eq_count;

    always #5 clk = ~clk;

    param_comparator_pipe #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .in_a        (in_a),
        .in_b        (in_b),
        .clr         (clr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_eq      (out_eq),
        .out_gt      (out_gt),
        .out_lt      (out_lt),
        .out_all_eq  (out_all_eq),
        .out_changed (out_changed),
        .eq_count    (eq_count)
    );

    typedef struct packed {
        logic [3:0] eq;
        logic [3:0] gt;
        logic [3:0] lt;
        logic       all_eq;
        logic [3:0] changed;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       last_exp;
    logic       m_valid;
    logic       m_hv;
    logic [2:0] m_hist [LANES];
    int         m_cnt;
    int         n_assert = 0;
    int         n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input exp_t e, input string tag);
        chk({tag, ".eq"},      32'(out_eq),      32'(e.eq));
        chk({tag, ".gt"},      32'(out_gt),      32'(e.gt));
        chk({tag, ".lt"},      32'(out_lt),      32'(e.lt));
        chk({tag, ".all_eq"},  32'(out_all_eq),  32'(e.all_eq));
        chk({tag, ".changed"}, 32'(out_changed), 32'(e.changed));
    endtask

    task automatic model_clear();
        m_hv  = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < LANES; i++) m_hist[i] = 3'b000;
    endtask

    // One clock cycle: drive at the falling edge, predict, then check at the next falling edge.
    task automatic cycle(input logic v, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic ordy, input string tag);
        logic       acc;
        exp_t       e;
        logic [2:0] codes [LANES];
        logic [7:0] av;
        logic [7:0] bv;
        in_valid  = v;
        in_signed = s;
        in_a      = a;
        in_b      = b;
        clr       = c;
        out_ready = ordy;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || ordy));
        acc = v && (!m_valid || ordy);
        if (acc) begin
            e = '0;
            for (int i = 0; i < LANES; i++) begin
                av = a[i*8 +: 8];
                bv = b[i*8 +: 8];
                if (s) begin
                    e.lt[i] = ($signed(av) < $signed(bv));
                    e.gt[i] = ($signed(av) > $signed(bv));
                end else begin
                    e.lt[i] = (av < bv);
                    e.gt[i] = (av > bv);
                end
                e.eq[i] = (av == bv);
                codes[i] = {e.lt[i], e.eq[i], e.gt[i]};
                e.changed[i] = m_hv && !c && (codes[i] != m_hist[i]);
            end
            e.all_eq = &e.eq;
            sb_q.push_back(e);
            if (c) begin
                model_clear();
            end else begin
                m_hv = 1'b1;
                for (int i = 0; i < LANES; i++) m_hist[i] = codes[i];
                if (e.all_eq && m_cnt < CNT_MAX) m_cnt++;
            end
            m_valid = 1'b1;
        end else begin
            if (c) model_clear();
            if (m_valid && ordy) m_valid = 1'b0;
        end
        @(negedge clk);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".eq_count"},  32'(eq_count),  m_cnt);
        if (acc) begin
            if (sb_q.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_outputs(e, tag);
                last_exp = e;
            end
        end else begin
            check_outputs(last_exp, {tag, ".hold"});
        end
    endtask

    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0;
        clr = 1'b0; out_ready = 1'b0;
        m_valid = 1'b0; last_exp = '0; model_clear();
        repeat (2) @(negedge clk);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.in_ready",  32'(in_ready),  32'd1);
        chk("reset.eq_count",  32'(eq_count),  32'd0);
        check_outputs('0, "reset");
        rst_n = 1'b1;

        // 1: basic unsigned transfer
        cycle(1'b1, 1'b0, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd40, 8'd5, 8'd25, 8'd10}, 1'b0, 1'b1, "t1");
        chk("t1.eq_const", 32'(out_eq), 32'h9);
        chk("t1.gt_const", 32'(out_gt), 32'h4);
        chk("t1.lt_const", 32'(out_lt), 32'h2);

        // 2: signed vs unsigned on lane 2, 0x80 vs 0x01
        cycle(1'b1, 1'b1, {8'd40, 8'h80, 8'd20, 8'd10}, {8'd40, 8'h01, 8'd25, 8'd10}, 1'b0, 1'b1, "t2s");
        chk("t2s.lt2", 32'(out_lt[2]), 32'd1);
        cycle(1'b1, 1'b0, {8'd40, 8'h80, 8'd20, 8'd10}, {8'd40, 8'h01, 8'd25, 8'd10}, 1'b0, 1'b1, "t2u");
        chk("t2u.gt2", 32'(out_gt[2]), 32'd1);
        chk("t2u.chg2", 32'(out_changed[2]), 32'd1);

        // 3: backpressure with in_valid held
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "t3drain");
        cycle(1'b1, 1'b0, 32'h01020304, 32'h04030201, 1'b0, 1'b0, "t3a");
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 1'b1, 32'hF0F1F2F3, 32'h01F1E203, 1'b0, 1'b0, "t3stall");
        cycle(1'b1, 1'b1, 32'hF0F1F2F3, 32'h01F1E203, 1'b0, 1'b1, "t3b");
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "t3end");

        // 4: counter saturation at 3
        for (int k = 0; k < 5; k++) begin
            ra = $urandom;
            cycle(1'b1, k[0], ra, ra, 1'b0, 1'b1, "t4");
        end
        chk("t4.sat", 32'(eq_count), 32'd3);

        // 5: clr together with an accepted all-equal transfer
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, "t5clr");
        cycle(1'b1, 1'b0, 32'h11223344, 32'h11223344, 1'b0, 1'b1, "t5e1");
        cycle(1'b1, 1'b0, 32'h55667788, 32'h55667788, 1'b0, 1'b1, "t5e2");
        chk("t5.cnt2", 32'(eq_count), 32'd2);
        cycle(1'b1, 1'b0, 32'hA0B0C0D0, 32'hA0B0C0D0, 1'b1, 1'b1, "t5clr_acc");
        chk("t5.cnt0", 32'(eq_count), 32'd0);
        cycle(1'b1, 1'b0, 32'hA0B0C0D0, 32'hA0B0C0D0, 1'b0, 1'b1, "t5next");
        chk("t5.cnt1", 32'(eq_count), 32'd1);

        // Random mix of valid, mode, clr and backpressure
        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rb = $urandom;
            for (int i = 0; i < LANES; i++)
                if ($urandom_range(0, 1) == 0) rb[i*8 +: 8] = ra[i*8 +: 8];
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ra, rb,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0, "rnd");
        end

        // 6: asynchronous reset with a stalled pending result
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "t6drain");
        cycle(1'b1, 1'b0, 32'h01010101, 32'h01010101, 1'b0, 1'b0, "t6load");
        cycle(1'b1, 1'b0, 32'h02020202, 32'h01010101, 1'b0, 1'b0, "t6stall");
        rst_n = 1'b0;
        #1;
        chk("t6.out_valid", 32'(out_valid), 32'd0);
        chk("t6.eq_count",  32'(eq_count),  32'd0);
        check_outputs('0, "t6");
        m_valid = 1'b0; last_exp = '0; model_clear(); sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 32'h02020202, 32'h01010101, 1'b0, 1'b1, "t6post");
        chk("t6post.chg", 32'(out_changed), 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "t6end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
